// File: rtl/umai_wdata_striper_pkg.sv
// Shared UMAI/AIB definitions: word geometry, header layout and striper states.
package umai_pkg;

    localparam logic [1:0]  DATA       = 2'b10;
    localparam int unsigned WORD_COUNT = 8;
    localparam int unsigned PAYLOAD_W  = 64;
    localparam int unsigned AIB_W      = 72;

    typedef struct packed {
        logic [1:0] wtype;
        logic [2:0] word_idx;
        logic       last;
        logic [1:0] seq;
    } hdr_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

endpackage

// File: rtl/umai_wdata_striper.sv
// Splits each 512-bit UMAI write-data beat into eight 72-bit AIB words and
// stripes them round-robin across a configurable contiguous channel group.
module umai_wdata_striper
    import umai_pkg::*;
#(
    parameter int unsigned NumChannels = 6,
    parameter int unsigned SeqWidth    = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [2:0]                    c_first_chn_id,
    input  logic [2:0]                    c_last_chn_id,
    input  logic                          i_wvalid,
    output logic                          o_wready,
    input  logic [511:0]                  i_wdata,
    output logic [NumChannels-1:0]        o_tx_valid,
    input  logic [NumChannels-1:0]        i_tx_ready,
    output logic [NumChannels*AIB_W-1:0]  o_tx_data,
    output logic                          o_busy,
    output logic                          o_cfg_err
);

    localparam logic [3:0] NCH = 4'(NumChannels);

    state_e                          state_q, state_d;
    logic [2:0]                      k_q, k_d;
    logic [2:0]                      ptr_q, ptr_d;
    logic [SeqWidth-1:0]             seq_q, seq_d;
    logic [SeqWidth-1:0]             tag_q, tag_d;
    logic [WORD_COUNT*PAYLOAD_W-1:0] hold_q, hold_d;

    logic       ready_sel;
    logic       hs;
    logic       accept;
    logic [2:0] ptr_adv;
    hdr_t       hdr;
    logic [AIB_W-1:0] word;

    always_comb begin
        o_cfg_err = (c_first_chn_id > c_last_chn_id) || ({1'b0, c_last_chn_id} >= NCH);
        // ptr can only be out of range while idle, so a plain compare-mux is safe
        ready_sel = 1'b0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (ptr_q == 3'(c)) ready_sel = i_tx_ready[c];
        end
        hs       = (state_q == ST_SEND) && ready_sel;
        o_wready = !i_rst && !o_cfg_err &&
                   ((state_q == ST_IDLE) || ((k_q == 3'd7) && hs));
        accept   = i_wvalid && o_wready;
        ptr_adv  = (ptr_q == c_last_chn_id) ? c_first_chn_id : ptr_q + 3'd1;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ptr_d   = ptr_q;
        seq_d   = seq_q;
        tag_d   = tag_q;
        hold_d  = hold_q;
        if (hs) begin
            ptr_d = ptr_adv;
            k_d   = k_q + 3'd1;
            if (k_q == 3'd7) state_d = ST_IDLE;
        end
        // Accept after the handshake update so a back-to-back beat sees the advanced ptr
        if (accept) begin
            state_d = ST_SEND;
            k_d     = 3'd0;
            hold_d  = i_wdata;
            tag_d   = seq_q;
            seq_d   = seq_q + SeqWidth'(1);
            if ((ptr_d < c_first_chn_id) || (ptr_d > c_last_chn_id)) ptr_d = c_first_chn_id;
        end
    end

    always_comb begin
        hdr.wtype    = DATA;
        hdr.word_idx = k_q;
        hdr.last     = (k_q == 3'd7);
        hdr.seq      = 2'(tag_q);
        word         = {hdr, hold_q[{k_q, 6'd0} +: PAYLOAD_W]};
        o_busy       = (state_q == ST_SEND);
        for (int unsigned c = 0; c < NumChannels; c++) begin
            o_tx_valid[c]                 = o_busy && (ptr_q == 3'(c));
            o_tx_data[c*AIB_W +: AIB_W]   = word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            ptr_q   <= c_first_chn_id;
            seq_q   <= '0;
            tag_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ptr_q   <= ptr_d;
            seq_q   <= seq_d;
            tag_q   <= tag_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_umai_wdata_striper.sv
// Self-checking bench for umai_wdata_striper: config table, directed corner
// sequences and randomized traffic against a word-queue reference model.
module tb_umai_wdata_striper;

    localparam int NCH = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       first = 3'd0, last = 3'd5;
    logic             wvalid = 1'b0;
    logic             wready;
    logic [511:0]     wdata = '0;
    logic [NCH-1:0]   tx_valid;
    logic [NCH-1:0]   tx_ready = '0;
    logic [NCH*72-1:0] tx_data;
    logic             busy, cfg_err;

    umai_wdata_striper #(.NumChannels(NCH), .SeqWidth(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .c_first_chn_id(first), .c_last_chn_id(last),
        .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata),
        .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_data(tx_data),
        .o_busy(busy), .o_cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: pending words of the held beat, in send order.
    logic [71:0] m_q[$];
    int          m_ptr = 0;
    int          m_seq = 0;
    logic        m_acc = 1'b0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_beat();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // One clock cycle: drive inputs, compare outputs to model, advance model.
    task automatic tick(input logic r, input logic v, input logic [511:0] d, input logic [NCH-1:0] rdy);
        logic cfg_exp, wr_exp, hs;
        logic [NCH-1:0] val_exp;
        rst = r; wvalid = v; wdata = d; tx_ready = rdy;
        #1;
        cfg_exp = (first > last) || (int'(last) >= NCH);
        val_exp = '0;
        if (m_q.size() != 0) val_exp[m_ptr] = 1'b1;
        hs      = (m_q.size() != 0) && rdy[m_ptr];
        wr_exp  = !r && !cfg_exp && ((m_q.size() == 0) || (m_q.size() == 1 && hs));
        chk("cfg_err", 72'(cfg_err), 72'(cfg_exp));
        chk("wready", 72'(wready), 72'(wr_exp));
        chk("busy", 72'(busy), 72'(m_q.size() != 0));
        chk("tx_valid", 72'(tx_valid), 72'(val_exp));
        if (m_q.size() != 0)
            for (int c = 0; c < NCH; c++) chk($sformatf("lane%0d", c), tx_data[c*72 +: 72], m_q[0]);
        m_acc = 1'b0;
        if (r) begin
            m_q.delete();
            m_ptr = int'(first);
            m_seq = 0;
        end else begin
            if (hs) begin
                void'(m_q.pop_front());
                m_ptr = (m_ptr == int'(last)) ? int'(first) : m_ptr + 1;
            end
            if (v && wr_exp) begin
                m_acc = 1'b1;
                if (m_ptr < int'(first) || m_ptr > int'(last)) m_ptr = int'(first);
                for (int k = 0; k < 8; k++)
                    m_q.push_back({8'(8'h80 + k*8 + (k == 7 ? 4 : 0) + m_seq), d[k*64 +: 64]});
                m_seq = (m_seq + 1) % 4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int budget = 200;
        while (m_q.size() != 0 && budget > 0) begin
            tick(1'b0, 1'b0, '0, '1);
            budget--;
        end
        chk("drain_timeout", 72'(m_q.size() != 0), 72'(0));
    endtask

    typedef struct {
        logic [2:0] f;
        logic [2:0] l;
        logic       err;
        logic       rdy;
    } cfg_vec_t;

    cfg_vec_t vecs[8];
    logic [511:0] beat_k;
    int accepts;
    int budget;

    initial begin
        vecs[0] = '{3'd0, 3'd5, 1'b0, 1'b1};
        vecs[1] = '{3'd4, 3'd1, 1'b1, 1'b0};
        vecs[2] = '{3'd0, 3'd6, 1'b1, 1'b0};
        vecs[3] = '{3'd5, 3'd5, 1'b0, 1'b1};
        vecs[4] = '{3'd7, 3'd7, 1'b1, 1'b0};
        vecs[5] = '{3'd2, 3'd3, 1'b0, 1'b1};
        vecs[6] = '{3'd3, 3'd2, 1'b1, 1'b0};
        vecs[7] = '{3'd0, 3'd0, 1'b0, 1'b1};
        for (int k = 0; k < 8; k++) beat_k[k*64 +: 64] = 64'(k);

        @(negedge clk);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, rand_beat(), '1);
        chk("rst_valid", 72'(tx_valid), 72'(0));
        chk("rst_busy", 72'(busy), 72'(0));

        // Configuration legality table, idle and no beat offered.
        for (int i = 0; i < 8; i++) begin
            first = vecs[i].f; last = vecs[i].l;
            rst = 1'b0; wvalid = 1'b0; #1;
            chk($sformatf("tbl_err%0d", i), 72'(cfg_err), 72'(vecs[i].err));
            chk($sformatf("tbl_rdy%0d", i), 72'(wready), 72'(vecs[i].rdy));
            tick(1'b0, 1'b0, '0, '1);
        end

        // Word k = k striped over 0..5, then a back-to-back second beat.
        first = 3'd0; last = 3'd5;
        tick(1'b0, 1'b1, beat_k, '1);
        chk("w0_valid", 72'(tx_valid), 72'(6'b000001));
        chk("w0_data", tx_data[71:0], {8'h80, 64'd0});
        accepts = 0; budget = 40;
        while (accepts < 1 && budget > 0) begin
            tick(1'b0, 1'b1, rand_beat(), '1);
            if (m_acc) accepts++;
            budget--;
        end
        chk("b2b_timeout", 72'(accepts), 72'(1));
        chk("b2b_valid", 72'(tx_valid), 72'(6'b000100));
        chk("b2b_hdr", 72'(tx_data[2*72+64 +: 8]), 72'(8'h81));
        drain();

        // Stall on channel 3 for five cycles while at word 1.
        first = 3'd2; last = 3'd3;
        tick(1'b0, 1'b1, rand_beat(), '1);
        tick(1'b0, 1'b0, '0, 6'b111111);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, '0, 6'b110111);
        chk("stall_valid", 72'(tx_valid), 72'(6'b001000));
        drain();

        // Illegal group blocks acceptance; legal group accepts next cycle.
        first = 3'd4; last = 3'd1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, rand_beat(), '1);
        first = 3'd0; last = 3'd5;
        tick(1'b0, 1'b1, rand_beat(), '1);
        chk("cfg_restore_acc", 72'(m_acc), 72'(1));
        chk("cfg_restore_busy", 72'(busy), 72'(1));
        drain();

        // Reset in the middle of a beat.
        tick(1'b0, 1'b1, rand_beat(), '1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, '0, '1);
        tick(1'b1, 1'b0, '0, '1);
        chk("midrst_valid", 72'(tx_valid), 72'(0));
        chk("midrst_busy", 72'(busy), 72'(0));
        tick(1'b0, 1'b1, beat_k, '1);
        chk("postrst_valid", 72'(tx_valid), 72'(6'b000001));
        chk("postrst_hdr", 72'(tx_data[71:64]), 72'(8'h80));
        drain();

        // Single-channel group, five beats.
        first = 3'd1; last = 3'd1;
        accepts = 0; budget = 100;
        while (accepts < 5 && budget > 0) begin
            tick(1'b0, 1'b1, rand_beat(), '1);
            if (m_acc) accepts++;
            budget--;
        end
        chk("single_timeout", 72'(accepts), 72'(5));
        drain();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if (m_q.size() == 0 && $urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    first = 3'($urandom_range(0, 7)); last = 3'($urandom_range(0, 7));
                end else begin
                    first = 3'($urandom_range(0, 5));
                    last  = 3'($urandom_range(int'(first), 5));
                end
            end
            tick($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rand_beat(),
                 NCH'($urandom | $urandom));
        end
        first = 3'd0; last = 3'd5;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
